// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, EX redirects and LSU waits,
// with a saturating bubble counter and a sticky LSU-timeout flag.
module hazard_ctrl #(
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned WAIT_W  = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1_idx,
   input  logic [4:0]       id_rs2_idx,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [4:0]       ex_rd_idx,
   input  logic             ex_wben,
   input  logic             ex_is_load,
   input  logic             ex_redirect,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_hold,
   output logic             idex_stall_n,
   output logic             exmem_stall,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] bubble_cnt
);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t            state;
   logic              redir_pend;
   logic [WAIT_W-1:0] wait_cnt;

   logic hold;
   logic redirect;
   logic load_use;
   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      hold = ~mem_ready & (((state == RUN) & mem_req) | (state == MEM_WAIT));
   end

   always_comb begin
      redirect = (ex_redirect | redir_pend) & ~hold;
   end

   always_comb begin
      rs1_hit  = id_rs1_used & (id_rs1_idx == ex_rd_idx);
      rs2_hit  = id_rs2_used & (id_rs2_idx == ex_rd_idx);
      load_use = ex_is_load & ex_wben & (ex_rd_idx != 5'd0) & id_valid & (rs1_hit | rs2_hit);
   end

   // Priority: hold > redirect > load-use > idle; everything idles while in reset.
   always_comb begin
      pc_stall     = 1'b0;
      ifid_stall   = 1'b0;
      ifid_flush   = 1'b0;
      idex_hold    = 1'b0;
      idex_stall_n = 1'b1;
      exmem_stall  = 1'b0;
      if (!rst) begin
         if (hold) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_hold   = 1'b1;
            exmem_stall = 1'b1;
         end else if (redirect) begin
            ifid_flush   = 1'b1;
            idex_stall_n = 1'b0;
         end else if (load_use) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall_n = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         redir_pend  <= 1'b0;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
         bubble_cnt  <= '0;
      end else begin
         state <= hold ? MEM_WAIT : RUN;
         // A redirect seen while held is parked until the release cycle consumes it.
         redir_pend <= hold ? (redir_pend | ex_redirect) : 1'b0;

         if ((state == MEM_WAIT) && !mem_ready) begin
            if (wait_cnt != '1) begin
               wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (wait_cnt == WAIT_W'(TIMEOUT)) begin
               mem_timeout <= 1'b1;
            end
         end else begin
            wait_cnt <= '0;
         end

         if (!idex_stall_n && !idex_hold && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, each cycle compared against a rule-level reference model.
module tb_hazard_ctrl;

   localparam int CNT_W   = 4;
   localparam int WAIT_W  = 3;
   localparam int TIMEOUT = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int WCNT_MAX = (1 << WAIT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             id_valid;
   logic [4:0]       id_rs1_idx;
   logic [4:0]       id_rs2_idx;
   logic             id_rs1_used;
   logic             id_rs2_used;
   logic [4:0]       ex_rd_idx;
   logic             ex_wben;
   logic             ex_is_load;
   logic             ex_redirect;
   logic             mem_req;
   logic             mem_ready;
   logic             pc_stall;
   logic             ifid_stall;
   logic             ifid_flush;
   logic             idex_hold;
   logic             idex_stall_n;
   logic             exmem_stall;
   logic             mem_timeout;
   logic [CNT_W-1:0] bubble_cnt;

   hazard_ctrl #(.CNT_W(CNT_W), .WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs1_idx   (id_rs1_idx),
      .id_rs2_idx   (id_rs2_idx),
      .id_rs1_used  (id_rs1_used),
      .id_rs2_used  (id_rs2_used),
      .ex_rd_idx    (ex_rd_idx),
      .ex_wben      (ex_wben),
      .ex_is_load   (ex_is_load),
      .ex_redirect  (ex_redirect),
      .mem_req      (mem_req),
      .mem_ready    (mem_ready),
      .pc_stall     (pc_stall),
      .ifid_stall   (ifid_stall),
      .ifid_flush   (ifid_flush),
      .idex_hold    (idex_hold),
      .idex_stall_n (idex_stall_n),
      .exmem_stall  (exmem_stall),
      .mem_timeout  (mem_timeout),
      .bubble_cnt   (bubble_cnt)
   );

   always #5 clk = ~clk;

   // Output vector order: {pc_stall, ifid_stall, ifid_flush, idex_hold, idex_stall_n, exmem_stall}
   localparam logic [5:0] O_IDLE  = 6'b000010;
   localparam logic [5:0] O_HOLD  = 6'b110111;
   localparam logic [5:0] O_REDIR = 6'b001000;
   localparam logic [5:0] O_LU    = 6'b110000;

   // Reference model state
   bit m_waiting;
   bit m_pend;
   int m_wcnt;
   bit m_tmo;
   int m_bub;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic clear_in();
      rst = 1'b0; id_valid = 1'b0; id_rs1_idx = '0; id_rs2_idx = '0;
      id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_rd_idx = '0; ex_wben = 1'b0;
      ex_is_load = 1'b0; ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic step();
      logic [5:0] exp_o;
      logic [5:0] got_o;
      bit held, redir, lu;
      @(negedge clk);
      held  = !mem_ready && (m_waiting || mem_req);
      redir = (ex_redirect || m_pend) && !held;
      lu    = ex_is_load && ex_wben && ex_rd_idx != 0 && id_valid &&
              ((id_rs1_used && id_rs1_idx == ex_rd_idx) || (id_rs2_used && id_rs2_idx == ex_rd_idx));
      if (rst)        exp_o = O_IDLE;
      else if (held)  exp_o = O_HOLD;
      else if (redir) exp_o = O_REDIR;
      else if (lu)    exp_o = O_LU;
      else            exp_o = O_IDLE;
      got_o = {pc_stall, ifid_stall, ifid_flush, idex_hold, idex_stall_n, exmem_stall};

      checks++;
      assert (got_o === exp_o) else begin
         failures++;
         $error("FAIL outs cyc=%0d got=%b exp=%b", cyc, got_o, exp_o);
      end
      checks++;
      assert (mem_timeout === m_tmo) else begin
         failures++;
         $error("FAIL mem_timeout cyc=%0d got=%b exp=%b", cyc, mem_timeout, m_tmo);
      end
      checks++;
      assert (bubble_cnt === CNT_W'(m_bub)) else begin
         failures++;
         $error("FAIL bubble_cnt cyc=%0d got=%0d exp=%0d", cyc, bubble_cnt, m_bub);
      end

      @(posedge clk);
      if (rst) begin
         m_waiting = 0; m_pend = 0; m_wcnt = 0; m_tmo = 0; m_bub = 0;
      end else begin
         if (m_waiting && !mem_ready) begin
            if (m_wcnt == TIMEOUT) m_tmo = 1;
            m_wcnt = (m_wcnt < WCNT_MAX) ? m_wcnt + 1 : WCNT_MAX;
         end else begin
            m_wcnt = 0;
         end
         if (exp_o[1] == 1'b0 && exp_o[2] == 1'b0 && m_bub < CNT_MAX) m_bub++;
         m_pend    = held ? (m_pend || ex_redirect) : 0;
         m_waiting = held;
      end
      cyc++;
      #1;
   endtask

   task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs2);
      ex_is_load = 1'b1; ex_wben = 1'b1; ex_rd_idx = rd;
      id_valid = 1'b1; id_rs2_used = 1'b1; id_rs2_idx = rs2;
   endtask

   initial begin
      clear_in();
      rst = 1'b1;
      m_waiting = 0; m_pend = 0; m_wcnt = 0; m_tmo = 0; m_bub = 0;
      @(posedge clk); #1;
      step();                                  // reset state
      clear_in(); step();

      // Load-use on rs2 gives one bubble
      set_load_use(5'd5, 5'd5); step();
      clear_in(); step();
      // rd=0 or id_valid=0 suppresses it
      set_load_use(5'd0, 5'd0); step();
      set_load_use(5'd5, 5'd5); id_valid = 1'b0; step();
      clear_in(); step();

      // Redirect overrides a load-use match
      set_load_use(5'd7, 5'd7); ex_redirect = 1'b1; step();
      clear_in(); step();

      // Three-cycle LSU wait then release
      mem_req = 1'b1; mem_ready = 1'b0;
      repeat (3) step();
      mem_ready = 1'b1; step();
      clear_in(); step();

      // Redirect during hold cycle 2 of a 4-cycle wait, applied at release
      mem_req = 1'b1; mem_ready = 1'b0; step();
      ex_redirect = 1'b1; step();
      ex_redirect = 1'b0; step(); step();
      mem_ready = 1'b1; step();
      clear_in(); step();
      step();

      // Timeout then stickiness, then reset mid-wait
      mem_req = 1'b1; mem_ready = 1'b0;
      repeat (7) step();
      mem_ready = 1'b1; step();
      clear_in(); step();
      set_load_use(5'd3, 5'd3); step();
      clear_in(); mem_req = 1'b1; ex_redirect = 1'b1; step();
      ex_redirect = 1'b0; step();
      rst = 1'b1; step();
      clear_in(); step();                      // RUN: no hold with mem_req=0
      step();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rst         = ($urandom_range(0, 59) == 0);
         id_valid    = ($urandom_range(0, 3) != 0);
         id_rs1_idx  = 5'($urandom_range(0, 3));
         id_rs2_idx  = 5'($urandom_range(0, 3));
         id_rs1_used = 1'($urandom);
         id_rs2_used = 1'($urandom);
         ex_rd_idx   = 5'($urandom_range(0, 3));
         ex_wben     = ($urandom_range(0, 3) != 0);
         ex_is_load  = 1'($urandom);
         ex_redirect = ($urandom_range(0, 7) == 0);
         mem_req     = ($urandom_range(0, 2) == 0);
         mem_ready   = ($urandom_range(0, 2) != 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
